// File: rtl/decim_pkg.sv
// Shared definitions for the decimation controller: FSM state encoding and
// the default width of the ratio / phase / sample counter.
// No logic; imported by decimation_controller and decim_mod_counter.
package decim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DECIM_CNT_W_DEFAULT = 4;

endpackage

// File: rtl/decim_mod_counter.sv
// Purpose : modulo-N sample counter; counts 0 .. modulus-1 and wraps to 0.
// Latency : count updates on the clock edge after en/clr; clr has priority over en.
// Backpressure: none; the counter holds its value whenever en is low.
// Ports   : clock, reset (sync, active-high), clr (synchronous clear),
//           en (advance one step), modulus (wrap value, must be non-zero),
//           count (current position).
module decim_mod_counter
  import decim_pkg::*;
#(
  parameter int cnt_width = DECIM_CNT_W_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [cnt_width-1:0] modulus,
  output logic [cnt_width-1:0] count
);

  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == modulus - CNT_ONE) begin
        count <= '0;
      end else begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/decimation_controller.sv
// Purpose : keeps one input sample in every R by driving the held-sample
//           register's hold line low on the selected counter position.
// Latency : hold is combinational; out_valid follows a kept sample by one cycle.
// Backpressure: none; sample_valid=0 simply freezes the counter.
// Ports   : clock, reset (sync, active-high), start/stop (control pulses),
//           ratio (decimation factor R), phase (optional, keep position),
//           sample_valid, hold, out_valid, busy (in RUN), cfg_err (sticky).
// Option  : define DECIM_PHASE_EN to add the phase input; otherwise the kept
//           position is fixed at count 0.
module decimation_controller
  import decim_pkg::*;
#(
  parameter int cnt_width = DECIM_CNT_W_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [cnt_width-1:0] ratio,
`ifdef DECIM_PHASE_EN
  input  logic [cnt_width-1:0] phase,
`endif
  input  logic                 sample_valid,
  output logic                 hold,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam logic [cnt_width-1:0] R_ONE = cnt_width'(1);

  state_t               state;
  state_t               state_nxt;
  logic [cnt_width-1:0] r_q;
  logic [cnt_width-1:0] phase_q;
  logic [cnt_width-1:0] count;
  logic                 cfg_legal;
  logic                 load;
  logic                 cfg_set;
  logic                 cnt_clr;
  logic                 cnt_en;

  // A zero ratio can never wrap, and a phase at or beyond the ratio would
  // never be reached by the counter.
`ifdef DECIM_PHASE_EN
  assign cfg_legal = (ratio != '0) && (phase < ratio);
`else
  assign cfg_legal = (ratio != '0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cfg_set   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          if (cfg_legal) begin
            load      = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = RUN;
          end else begin
            cfg_set   = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_en = sample_valid;
        if (stop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration is captured only on a legal start; in RUN the ratio and
  // phase inputs are free to change without effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q     <= R_ONE;
      cfg_err <= 1'b0;
    end else begin
      if (load) begin
        r_q     <= ratio;
        cfg_err <= 1'b0;
      end else if (cfg_set) begin
        cfg_err <= 1'b1;
      end
    end
  end

`ifdef DECIM_PHASE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
    end else if (load) begin
      phase_q <= phase;
    end
  end
`else
  assign phase_q = '0;
`endif

  decim_mod_counter #(
    .cnt_width (cnt_width)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .modulus (r_q),
    .count   (count)
  );

  // Decoded from the current state, so a sample arriving with stop is still
  // kept when its position matches.
  assign hold = !((state == RUN) && sample_valid && (count == phase_q));
  assign busy = (state == RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= !hold;
    end
  end

endmodule

// File: tb/tb_decimation_controller.sv
// Directed bench for decimation_controller: inputs change on the falling
// edge, outputs are compared 1 time unit later against hand-derived values.
module tb_decimation_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] ratio;
  logic [3:0] phase;
  logic       sample_valid;
  logic       hold;
  logic       out_valid;
  logic       busy;
  logic       cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  decimation_controller #(
    .cnt_width (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .ratio        (ratio),
`ifdef DECIM_PHASE_EN
    .phase        (phase),
`endif
    .sample_valid (sample_valid),
    .hold         (hold),
    .out_valid    (out_valid),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle of stimulus; returns with outputs settled for that cycle.
  task automatic cyc(input logic st, input logic sp, input logic sv,
                     input logic [3:0] r);
    @(negedge clock);
    start        = st;
    stop         = sp;
    sample_valid = sv;
    ratio        = r;
    #1;
  endtask

  initial begin
    logic exp_keep [7];
    logic prev_keep;

    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    ratio        = 4'd0;
    phase        = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_hold",      hold,      1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_cfg_err",   cfg_err,   0);
    @(negedge clock);
    reset = 1'b0;

    // R=4, twelve consecutive valids; start and ratio changes in RUN are ignored
    cyc(1, 0, 0, 4);
    check("r4_start_busy", busy, 0);
    check("r4_start_hold", hold, 1);
    for (int i = 1; i <= 12; i++) begin
      cyc((i == 3), 0, 1, (i > 1) ? 4'd7 : 4'd4);
      check($sformatf("r4_hold_%0d", i),  hold,      ((i % 4) == 1) ? 0 : 1);
      check($sformatf("r4_ovld_%0d", i),  out_valid, ((i % 4) == 2) ? 1 : 0);
      check($sformatf("r4_busy_%0d", i),  busy,      1);
    end
    cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 4);
    check("r4_stop_busy", busy,      0);
    check("r4_stop_ovld", out_valid, 0);

    // R=3 with gaps: valid pattern 1,0,1,1,0,1,1 keeps counts 0 -> cycles 1 and 6
    exp_keep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cyc(1, 0, 0, 3);
    prev_keep = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, (i == 1 || i == 4) ? 1'b0 : 1'b1, 3);
      check($sformatf("r3_hold_%0d", i + 1), hold,      !exp_keep[i]);
      check($sformatf("r3_ovld_%0d", i + 1), out_valid, prev_keep);
      prev_keep = exp_keep[i];
    end
    cyc(0, 1, 0, 3);
    check("r3_tail_ovld", out_valid, 0);

    // illegal ratio 0, then a legal start clears the sticky error
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("cfg0_busy", busy,    0);
    check("cfg0_err",  cfg_err, 1);
    cyc(0, 0, 0, 0);
    check("cfg0_sticky", cfg_err, 1);
    cyc(1, 0, 0, 2);
    cyc(0, 0, 0, 2);
    check("cfg2_err",  cfg_err, 0);
    check("cfg2_busy", busy,    1);

    // stop at count 2 with R=4, restart with R=2
    cyc(0, 1, 0, 2);
    cyc(1, 0, 0, 4);
    cyc(0, 0, 1, 4);
    check("stp_c0_hold", hold, 0);
    cyc(0, 0, 1, 4);
    check("stp_c1_hold", hold, 1);
    cyc(0, 1, 0, 4);
    check("stp_busy_pre", busy, 1);
    cyc(0, 0, 0, 4);
    check("stp_busy_post", busy, 0);
    check("stp_hold_idle", hold, 1);
    cyc(1, 0, 0, 2);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 1, 2);
      check($sformatf("rs2_hold_%0d", i), hold, ((i % 2) == 1) ? 0 : 1);
    end

    // count is now 1; next valid wraps to 0, then a kept sample coincides with stop
    cyc(0, 0, 1, 2);
    check("stpk_pre_hold", hold, 1);
    cyc(0, 1, 1, 2);
    check("stpk_hold", hold, 0);
    cyc(0, 0, 0, 2);
    check("stpk_ovld", out_valid, 1);
    check("stpk_busy", busy,      0);
    check("stpk_idle_hold", hold, 1);

    // reset mid-RUN on a kept sample: no out_valid afterwards
    cyc(1, 0, 0, 2);
    cyc(0, 0, 1, 2);
    cyc(0, 0, 1, 2);
    @(negedge clock);
    reset        = 1'b1;
    sample_valid = 1'b1;
    #1;
    check("mrst_hold_pre", hold, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mrst_ovld", out_valid, 0);
    check("mrst_busy", busy,      0);
    check("mrst_hold", hold,      1);

    // start and stop together in IDLE
    cyc(1, 1, 1, 3);
    cyc(0, 0, 1, 3);
    check("ss_busy", busy,      0);
    check("ss_hold", hold,      1);
    check("ss_ovld", out_valid, 0);
    check("ss_err",  cfg_err,   0);

`ifdef DECIM_PHASE_EN
    // phase 3 with R=4 keeps samples 4, 8, 12; phase 4 is illegal
    phase = 4'd3;
    cyc(1, 0, 0, 4);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 1, 4);
      check($sformatf("ph3_hold_%0d", i), hold, ((i % 4) == 0) ? 0 : 1);
    end
    cyc(0, 1, 0, 4);
    phase = 4'd4;
    cyc(1, 0, 0, 4);
    cyc(0, 0, 1, 4);
    check("ph4_err",  cfg_err, 1);
    check("ph4_busy", busy,    0);
    check("ph4_hold", hold,    1);
    phase = 4'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
